// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux path: owner index drives the mux
// select, the one-hot grant mirrors the 2:4 decoder output.
module mux4_arbiter #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned HOLD_W   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       En,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state, state_nxt;
   logic [1:0]        last, last_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [3:0]        gnt_nxt;
   logic [1:0]        sel_nxt;
   logic              busy_nxt;
   logic [2:0]        pick_all, pick_oth;

   // Returns {found, index} of the first set request after base, wrapping mod 4.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
      logic       found;
      logic [1:0] idx;
      logic [1:0] win;
      found = 1'b0;
      win   = base;
      for (int i = 1; i <= 4; i++) begin
         idx = base + 2'(i);
         if (!found && r[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      return {found, win};
   endfunction

   // Candidates: any requester (from IDLE) and any requester other than the owner.
   always_comb begin
      pick_all = rr_pick(req, last);
      pick_oth = rr_pick(req & ~(4'b0001 << sel), sel);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= 4'b0000;
         sel      <= 2'b00;
         busy     <= 1'b0;
         last     <= 2'b11;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         sel      <= sel_nxt;
         busy     <= busy_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      sel_nxt   = sel;
      busy_nxt  = busy;
      last_nxt  = last;
      hold_nxt  = hold_cnt;

      unique case (state)
         IDLE: begin
            gnt_nxt  = 4'b0000;
            busy_nxt = 1'b0;
            if (En && pick_all[2]) begin
               state_nxt = GRANT;
               gnt_nxt   = 4'b0001 << pick_all[1:0];
               sel_nxt   = pick_all[1:0];
               last_nxt  = pick_all[1:0];
               busy_nxt  = 1'b1;
               hold_nxt  = '0;
            end
         end
         GRANT: begin
            if (!En) begin
               state_nxt = IDLE;
               gnt_nxt   = 4'b0000;
               busy_nxt  = 1'b0;
               hold_nxt  = '0;
            end else if (!req[sel] ||
                         (MAX_HOLD != 0 && hold_cnt == HOLD_LAST && pick_oth[2])) begin
               // Release or preemption: hand over directly, no idle cycle.
               if (pick_oth[2]) begin
                  gnt_nxt  = 4'b0001 << pick_oth[1:0];
                  sel_nxt  = pick_oth[1:0];
                  last_nxt = pick_oth[1:0];
                  busy_nxt = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = 4'b0000;
                  busy_nxt  = 1'b0;
               end
               hold_nxt = '0;
            end else if (hold_cnt != HOLD_LAST) begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Scoreboard bench for mux4_arbiter: a behavioural owner/pointer model queues
// the expected outputs per edge; a monitor pops and compares after each edge.
module tb_mux4_arbiter;

   localparam int MAX_HOLD = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;

   mux4_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .En(en), .req(req),
      .gnt(gnt), .sel(sel), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;

   // Reference model: owner index (-1 = idle), last winner, cycles held so far.
   int m_owner = -1;
   int m_last  = 3;
   int m_sel   = 0;
   int m_held  = 0;

   function automatic int pick(logic [3:0] r, int base, int excl);
      for (int k = 1; k <= 4; k++) begin
         int idx;
         idx = (base + k) % 4;
         if (idx != excl && r[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic void take(int w);
      m_owner = w;
      m_sel   = w;
      m_last  = w;
      m_held  = 1;
   endfunction

   function automatic void model_step(logic rst, logic e, logic [3:0] r);
      int w;
      if (!rst) begin
         m_owner = -1; m_sel = 0; m_last = 3; m_held = 0;
      end else if (m_owner < 0) begin
         w = pick(r, m_last, -1);
         if (e && w >= 0) take(w);
      end else if (!e) begin
         m_owner = -1;
      end else if (!r[m_owner]) begin
         w = pick(r, m_owner, m_owner);
         if (w >= 0) take(w);
         else m_owner = -1;
      end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && pick(r, m_owner, m_owner) >= 0) begin
         take(pick(r, m_owner, m_owner));
      end else begin
         m_held++;
      end
   endfunction

   // Drive one edge's inputs, advance the model, queue what the DUT must show after the edge.
   task automatic cyc(input logic rst, input logic e, input logic [3:0] r);
      exp_t x;
      rst_n = rst;
      en    = e;
      req   = r;
      model_step(rst, e, r);
      x.gnt  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      x.sel  = 2'(m_sel);
      x.busy = (m_owner >= 0);
      exp_q.push_back(x);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
      end
   endtask

   // Monitor: outputs are presented every cycle, compared just after the edge.
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (!done) begin
         if (exp_q.size() == 0) begin
            chk("queue_underflow", 32'd1, 32'd0);
         end else begin
            x = exp_q.pop_front();
            chk("gnt", 32'(gnt), 32'(x.gnt));
            chk("sel", 32'(sel), 32'(x.sel));
            chk("busy", 32'(busy), 32'(x.busy));
            chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("inv_busy", 32'(busy), 32'(|gnt));
            if (busy) chk("inv_gnt_sel", 32'(gnt), 32'(4'b0001 << sel));
         end
      end
   end

   initial begin
      logic [3:0] r;
      // Reset, first grant to requester 0, then reset mid-grant.
      cyc(0, 1, 4'b0000);
      cyc(0, 1, 4'b0000);
      cyc(1, 1, 4'b0001);
      cyc(1, 1, 4'b0001);
      cyc(0, 1, 4'b0001);
      cyc(1, 0, 4'b0000);
      // Fairness: all requesting, each owner drops after a 2-cycle grant.
      for (int i = 0; i < 14; i++) begin
         r = 4'b1111;
         if (m_owner >= 0 && m_held == 2) r[m_owner] = 1'b0;
         cyc(1, 1, r);
      end
      // Preemption with two contenders, then a lone requester.
      cyc(0, 1, 4'b0000);
      for (int i = 0; i < 30; i++) cyc(1, 1, 4'b0011);
      cyc(1, 0, 4'b0000);
      for (int i = 0; i < 25; i++) cyc(1, 1, 4'b0001);
      // Rotation: owner 2 releases with 1011 -> 3; owner 3 releases with 0011 -> 0.
      cyc(0, 1, 4'b0000);
      cyc(1, 1, 4'b0100);
      cyc(1, 1, 4'b0100);
      cyc(1, 1, 4'b1011);
      cyc(1, 1, 4'b1011);
      cyc(1, 1, 4'b0011);
      cyc(1, 1, 4'b0011);
      // Enable drop, then re-enable after last=1; release coincident with En=0.
      cyc(0, 1, 4'b0000);
      cyc(1, 1, 4'b0010);
      cyc(1, 0, 4'b0010);
      cyc(1, 1, 4'b1111);
      cyc(1, 1, 4'b1111);
      cyc(1, 0, 4'b1011);
      cyc(1, 1, 4'b0000);
      // Random traffic with sticky requests, occasional enable drops and resets.
      r = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) r = r ^ 4'($urandom_range(0, 15));
         cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 15) != 0), r);
      end
      done = 1'b1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
